booth_product_accumulator: RTL and testbench

Downstream stage of the 8-bit sequential Booth multiplier. It detects each completed product from the multiplier's level-type ready, sign-extends and accumulates BATCH products into a saturating signed sum, and queues finished batch sums in a small FIFO. Consumers read the FIFO over a valid/ready stream.

---
 rtl/booth_pkg.sv | 47 ++++
 rtl/booth_acc_fifo.sv | 62 ++++++
 rtl/booth_product_accumulator.sv | 127 ++++++++++++
 tb/tb_booth_product_accumulator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth product accumulator slice.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package booth_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;

    // Working width of the saturating adder; wide enough for any ACC_W up to 62.
    localparam int SAT_W = 64;

    // One queued batch result at the default accumulator width.
    typedef struct packed {
        logic                        sat;
        logic signed [ACC_W_DEF-1:0] sum;
    } acc_entry_t;

    // Saturating-add result: clamped value plus a flag showing the clamp fired.
    typedef struct packed {
        logic                    fired;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Adds two sign-extended operands and clamps to the signed range of w bits.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int                      w);
        sat_res_t                r;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.fired = 1'b0;
        r.val   = s;
        if (s > hi) begin
            r.val   = hi;
            r.fired = 1'b1;
        end else if (s < lo) begin
            r.val   = lo;
            r.fired = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_acc_fifo.sv
// Synchronous FIFO holding finished batch entries (sum plus saturation flag).
// Latency: a push is visible at the head one cycle later; head is gated to zero when empty.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module booth_acc_fifo
    import booth_pkg::*;
#(
    parameter int W     = $bits(acc_entry_t),
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = count;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset because the head is gated while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Captures each Booth product on the rising edge of mul_rdy and sums BATCH of them with saturation.
// Latency: capture cycle C gives out_valid in cycle C+2 when it completes a batch into an empty FIFO.
// Backpressure: out_valid/out_ready stream; a batch finishing into a full FIFO without a pop is lost and flagged.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int BATCH  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mul_rdy,
    input  logic [PROD_W-1:0]      mul_p,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_sat,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow_err
);

    localparam int CW = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BATCH - 1);

    typedef struct packed {
        logic                    sat;
        logic signed [ACC_W-1:0] sum;
    } entry_t;

    logic                    rdy_q;
    logic                    capture;
    logic signed [ACC_W-1:0] prod_q;
    logic                    prod_v;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           cnt;
    logic                    sat_acc;
    sat_res_t                add_res;
    logic signed [ACC_W-1:0] sum_cl;
    logic                    batch_done;
    entry_t                  push_entry;
    entry_t                  head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    dropped;

    // rdy_q starts high so a level already asserted at reset release is not a new product.
    assign capture = mul_rdy & ~rdy_q;

    // Remember last cycle's ready level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdy_q <= 1'b1;
        else       rdy_q <= mul_rdy;
    end

    // Stage 1: register the sign-extended product; clr kills a product in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_v <= capture & ~clr;
            if (capture) prod_q <= ACC_W'($signed(mul_p));
        end
    end

    // Saturating sum of the running total and the staged product, plus the entry to queue.
    always_comb begin
        add_res    = sat_add(SAT_W'(acc), SAT_W'(prod_q), ACC_W);
        sum_cl     = ACC_W'(add_res.val);
        batch_done = prod_v & ~clr & (cnt == LAST);
        push_entry.sat = sat_acc | add_res.fired;
        push_entry.sum = sum_cl;
    end

    // Stage 2: accumulate, or close the batch and restart; clr wins over the update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
        end else if (prod_v) begin
            if (cnt == LAST) begin
                acc     <= '0;
                cnt     <= '0;
                sat_acc <= 1'b0;
            end else begin
                acc     <= sum_cl;
                cnt     <= cnt + CW'(1);
                sat_acc <= sat_acc | add_res.fired;
            end
        end
    end

    booth_acc_fifo #(
        .W     (ACC_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (batch_done),
        .push_data (push_entry),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = ~fifo_empty;
    assign out_sum   = head.sum;
    assign out_sat   = head.sat;
    assign dropped   = batch_done & fifo_full & ~(out_ready & out_valid);

    // Sticky flag for a finished batch lost to a full FIFO; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        overflow_err <= 1'b0;
        else if (dropped) overflow_err <= 1'b1;
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mul_rdy = 1'b0;
    logic [15:0] mul_p = '0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;

    logic        v24, t24, o24, v18, t18, o18;
    logic [23:0] s24;
    logic [17:0] s18;
    logic [2:0]  l24, l18;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_product_accumulator u24 (
        .clk(clk), .reset(reset), .mul_rdy(mul_rdy), .mul_p(mul_p), .clr(clr),
        .out_valid(v24), .out_ready(out_ready), .out_sum(s24), .out_sat(t24),
        .fifo_level(l24), .overflow_err(o24)
    );

    booth_product_accumulator #(.ACC_W(18)) u18 (
        .clk(clk), .reset(reset), .mul_rdy(mul_rdy), .mul_p(mul_p), .clr(clr),
        .out_valid(v18), .out_ready(out_ready), .out_sum(s18), .out_sat(t18),
        .fifo_level(l18), .overflow_err(o18)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Products arrive one edge after the capture cycle and are summed one edge later;
    // the model keeps a plain integer running total per width and a queue of results.
    typedef struct {
        longint s24;
        bit     t24;
        longint s18;
        bit     t18;
    } ment_t;

    ment_t  mq[$];
    bit     m_ovf, m_prev, m_p1v;
    longint m_p1;
    longint m_acc [2];
    bit     m_sat [2];
    int     m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_prev = 1; m_p1v = 0; m_p1 = 0; m_cnt = 0;
            for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
        end else begin
            bit     cap, popd, pushd;
            ment_t  e;
            longint s, hi;
            int     w;
            cap   = mul_rdy && !m_prev;
            popd  = (mq.size() > 0) && out_ready;
            pushd = 0;
            e = '{0, 0, 0, 0};
            if (clr) begin
                for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
                m_cnt = 0;
            end else if (m_p1v) begin
                for (int k = 0; k < 2; k++) begin
                    w  = (k == 0) ? 24 : 18;
                    hi = (longint'(1) << (w - 1)) - 1;
                    s  = m_acc[k] + m_p1;
                    if (s > hi) begin s = hi; m_sat[k] = 1; end
                    else if (s < -hi - 1) begin s = -hi - 1; m_sat[k] = 1; end
                    m_acc[k] = s;
                end
                if (m_cnt == 7) begin
                    e = '{m_acc[0], m_sat[0], m_acc[1], m_sat[1]};
                    pushd = 1;
                    for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (popd) void'(mq.pop_front());
            if (pushd) begin
                if (mq.size() < 4) mq.push_back(e);
                else m_ovf = 1;
            end
            m_p1v  = cap && !clr;
            m_p1   = longint'($signed(mul_p));
            m_prev = mul_rdy;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("m.valid24", v24, mq.size() > 0);
            chk("m.valid18", v18, mq.size() > 0);
            chk("m.level24", l24, mq.size());
            chk("m.level18", l18, mq.size());
            chk("m.ovf24", o24, m_ovf);
            chk("m.ovf18", o18, m_ovf);
            if (mq.size() > 0) begin
                chk("m.sum24", longint'($signed(s24)), mq[0].s24);
                chk("m.sat24", t24, mq[0].t24);
                chk("m.sum18", longint'($signed(s18)), mq[0].s18);
                chk("m.sat18", t18, mq[0].t18);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prod(input logic [15:0] p);
        mul_p = p; mul_rdy = 1'b1; cyc(3);
        mul_rdy = 1'b0; cyc(2);
    endtask

    task automatic batch(input logic [15:0] p);
        for (int i = 0; i < 8; i++) prod(p);
    endtask

    task automatic pop_check(input string nm, input longint e24, input bit st24,
                             input longint e18, input bit st18);
        for (int i = 0; i < 20 && !v24; i++) cyc(1);
        chk({nm, ".valid"}, v24, 1);
        chk({nm, ".sum24"}, longint'(s24), e24);
        chk({nm, ".sat24"}, t24, st24);
        chk({nm, ".sum18"}, longint'(s18), e18);
        chk({nm, ".sat18"}, t18, st18);
        out_ready = 1'b1; cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        cyc(2);
        #1 chk("rst.valid", v24, 0);
        chk("rst.sum", longint'(s24), 0);
        chk("rst.sat", t24, 0);
        chk("rst.level", l24, 0);
        chk("rst.ovf", o24, 0);
        @(negedge clk) reset = 1'b0;
        cyc(2);

        // Eight +100 products; the last one checked for C+2 latency.
        for (int i = 0; i < 7; i++) prod(16'h0064);
        mul_p = 16'h0064; mul_rdy = 1'b1;
        cyc(1); chk("lat.c1", v24, 0);
        cyc(1); chk("lat.c2", v24, 1);
        cyc(1); mul_rdy = 1'b0; cyc(2);
        pop_check("pos100", 'h000320, 0, 'h00320, 0);

        // Eight -100 products, the first held high for 10 cycles.
        mul_p = 16'hFF9C; mul_rdy = 1'b1; cyc(10);
        mul_rdy = 1'b0; cyc(2);
        for (int i = 0; i < 6; i++) prod(16'hFF9C);
        cyc(3); chk("held.once", v24, 0);
        prod(16'hFF9C);
        pop_check("neg100", 'hFFFCE0, 0, 'h3FCE0, 0);

        // Saturation in the 18-bit instance, then a clean batch.
        batch(16'h7FFF);
        pop_check("sat", 'h03FFF8, 0, 'h1FFFF, 1);
        batch(16'h0001);
        pop_check("after_sat", 8, 0, 8, 0);

        // Five batches with no reader: FIFO fills and the fifth is lost.
        batch(16'h0001); batch(16'h0001); batch(16'h0001); batch(16'h0001); batch(16'h0001);
        cyc(3);
        chk("full.level", l24, 4);
        chk("full.ovf", o24, 1);
        chk("full.ovf18", o18, 1);
        for (int i = 0; i < 4; i++) pop_check("drain", 8, 0, 8, 0);
        cyc(1);
        chk("drain.valid", v24, 0);
        chk("drain.ovf", o24, 1);

        // Idle clr discards a partial batch.
        prod(16'd5); prod(16'd5); prod(16'd5);
        clr = 1'b1; cyc(1); clr = 1'b0;
        batch(16'd2);
        pop_check("clr_idle", 16, 0, 16, 0);

        // clr during stage 2 discards that product.
        mul_p = 16'd7; mul_rdy = 1'b1; cyc(1);
        clr = 1'b1; cyc(1); clr = 1'b0;
        cyc(1); mul_rdy = 1'b0; cyc(2);
        batch(16'd2);
        pop_check("clr_stage2", 16, 0, 16, 0);
        cyc(1);
        chk("clr_stage2.empty", v24, 0);

        // Reset with two queued entries and a partial batch; ready high across release.
        batch(16'd1); batch(16'd1);
        prod(16'd1); prod(16'd1); prod(16'd1);
        chk("pre_rst.level", l24, 2);
        mul_p = 16'd100; mul_rdy = 1'b1;
        reset = 1'b1;
        #1 chk("rst2.valid", v24, 0);
        chk("rst2.level", l24, 0);
        chk("rst2.ovf", o24, 0);
        cyc(2);
        reset = 1'b0;
        cyc(4);
        mul_rdy = 1'b0; cyc(2);
        batch(16'd1);
        pop_check("post_rst", 8, 0, 8, 0);
        cyc(1);
        chk("post_rst.empty", v24, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
